change_dispenser_seq: RTL and testbench

//  Sequential coin-change payout stage, downstream of vending_machine. It accepts a change amount
//  in cents and ejects coins one at a time to the coin hopper: greedy quarter > dime > nickel,

---
 rtl/vm_pkg.sv | 38 +++
 rtl/dispense_timer.sv | 28 ++
 rtl/change_dispenser_seq.sv | 194 +++++++++++++++++++
 tb/tb_change_dispenser_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine constants: coin values, coin-select codes,
// payout FSM state encoding and small arithmetic helpers.
package vm_pkg;

    localparam logic [8:0] COIN_QUARTER = 9'd25;
    localparam logic [8:0] COIN_DIME    = 9'd10;
    localparam logic [8:0] COIN_NICKEL  = 9'd5;

    // Coin select: which solenoid the current payout step drives.
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_Q    = 2'd1;
    localparam logic [1:0] SEL_D    = 2'd2;
    localparam logic [1:0] SEL_N    = 2'd3;

    // Payout FSM states.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_EJECT    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_FIN      = 3'd5;
    localparam logic [2:0] ST_FAULT    = 3'd6;

    function automatic logic [8:0] coin_value(input logic [1:0] sel);
        case (sel)
            SEL_Q:   return COIN_QUARTER;
            SEL_D:   return COIN_DIME;
            SEL_N:   return COIN_NICKEL;
            default: return 9'd0;
        endcase
    endfunction

    // Per-transaction coin counters stop at 31 instead of wrapping.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter. expired is high whenever the count is zero, so a
// load of N-1 gives a phase that lasts exactly N cycles.
module dispense_timer #(
    parameter int W = 10
) (
    input  logic         clk2,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk2) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser_seq.sv
// Sequential coin-change payout: greedy quarter/dime/nickel selection with
// stock fallback, one coin per eject pulse, hopper-confirmed, with timeout fault.
// Handshake: a request transfers on a rising clk2 edge where change_valid and
// change_ready are both high; change_ready is high only in IDLE.
module change_dispenser_seq
    import vm_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 1000,
    parameter int GAP_CYCLES   = 2,
    parameter int STOCK_W      = 6
) (
    input  logic               clk2,
    input  logic               rst,
    input  logic               change_valid,
    input  logic [8:0]         change_amt,
    output logic               change_ready,
    input  logic               refill,
    input  logic [STOCK_W-1:0] refill_q,
    input  logic [STOCK_W-1:0] refill_d,
    input  logic [STOCK_W-1:0] refill_n,
    input  logic               coin_ack,
    output logic               eject_q,
    output logic               eject_d,
    output logic               eject_n,
    output logic               busy,
    output logic               done,
    output logic               short_change,
    output logic               fault,
    output logic [8:0]         remaining,
    output logic [4:0]         quarter_cnt,
    output logic [4:0]         dime_cnt,
    output logic [4:0]         nickel_cnt,
    output logic [STOCK_W-1:0] stock_q,
    output logic [STOCK_W-1:0] stock_d,
    output logic [STOCK_W-1:0] stock_n,
    output logic [2:0]         fsm_state
);

    localparam int TMAX = (ACK_TIMEOUT > PULSE_CYCLES)
                        ? ((ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES)
                        : ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
    localparam int TIMER_W = $clog2(TMAX + 1);

    logic [2:0]         state;
    logic [1:0]         coin;
    logic [1:0]         pick;
    logic               ack_pend;
    logic               ack_now;
    logic               accept;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_expired;

    assign accept  = change_valid && change_ready;
    // An ack that arrived while the solenoid was still pulsing counts once here.
    assign ack_now = coin_ack || ack_pend;

    // Greedy selector: largest coin that fits in what is owed and is in stock.
    always_comb begin
        pick = SEL_NONE;
        if (remaining >= COIN_QUARTER && stock_q != '0) begin
            pick = SEL_Q;
        end else if (remaining >= COIN_DIME && stock_d != '0) begin
            pick = SEL_D;
        end else if (remaining >= COIN_NICKEL && stock_n != '0) begin
            pick = SEL_N;
        end
    end

    // One shared timer, reloaded on entry to EJECT, WAIT_ACK and GAP.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state == ST_SELECT && pick != SEL_NONE) begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(PULSE_CYCLES - 1);
        end else if (state == ST_EJECT && tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(ACK_TIMEOUT - 1);
        end else if (state == ST_WAIT_ACK && ack_now) begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(GAP_CYCLES - 1);
        end
    end

    dispense_timer #(.W(TIMER_W)) u_timer (
        .clk2     (clk2),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Payout FSM: state, latched coin choice and early-ack capture.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state    <= ST_IDLE;
            coin     <= SEL_NONE;
            ack_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_SELECT;
                end
                ST_SELECT: begin
                    ack_pend <= 1'b0;
                    if (pick == SEL_NONE) begin
                        state <= ST_FIN;
                    end else begin
                        state <= ST_EJECT;
                        coin  <= pick;
                    end
                end
                ST_EJECT: begin
                    if (coin_ack) ack_pend <= 1'b1;
                    if (tmr_expired) state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_now) begin
                        state    <= ST_GAP;
                        ack_pend <= 1'b0;
                    end else if (tmr_expired) begin
                        state <= ST_FAULT;
                    end
                end
                ST_GAP: begin
                    if (tmr_expired) state <= ST_SELECT;
                end
                ST_FIN:   state <= ST_IDLE;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Stock, amount owed, per-coin counts and the shortfall flag.
    always_ff @(posedge clk2) begin
        if (rst) begin
            stock_q      <= '0;
            stock_d      <= '0;
            stock_n      <= '0;
            remaining    <= '0;
            quarter_cnt  <= '0;
            dime_cnt     <= '0;
            nickel_cnt   <= '0;
            short_change <= 1'b0;
        end else begin
            if (state == ST_IDLE && refill) begin
                stock_q <= refill_q;
                stock_d <= refill_d;
                stock_n <= refill_n;
            end
            if (accept) begin
                remaining    <= change_amt;
                quarter_cnt  <= '0;
                dime_cnt     <= '0;
                nickel_cnt   <= '0;
                short_change <= 1'b0;
            end
            if (state == ST_SELECT && pick == SEL_NONE) begin
                short_change <= (remaining != '0);
            end
            if (state == ST_WAIT_ACK && ack_now) begin
                remaining <= remaining - coin_value(coin);
                case (coin)
                    SEL_Q: begin
                        stock_q     <= stock_q - STOCK_W'(1);
                        quarter_cnt <= sat_inc(quarter_cnt);
                    end
                    SEL_D: begin
                        stock_d  <= stock_d - STOCK_W'(1);
                        dime_cnt <= sat_inc(dime_cnt);
                    end
                    SEL_N: begin
                        stock_n    <= stock_n - STOCK_W'(1);
                        nickel_cnt <= sat_inc(nickel_cnt);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign change_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FIN);
    assign fault        = (state == ST_FAULT);
    assign eject_q      = (state == ST_EJECT) && (coin == SEL_Q);
    assign eject_d      = (state == ST_EJECT) && (coin == SEL_D);
    assign eject_n      = (state == ST_EJECT) && (coin == SEL_N);
    assign fsm_state    = state;

endmodule

// File: tb/tb_change_dispenser_seq.sv
// Bench for change_dispenser_seq: directed table, random payouts against a
// greedy reference model, and hand-written fault / mid-payout reset sequences.
`timescale 1ns/1ps
module tb_change_dispenser_seq;

    localparam int PULSE  = 4;
    localparam int ACK_TO = 1000;
    localparam int GAP    = 2;

    logic       clk2 = 1'b0;
    logic       rst = 1'b1;
    logic       change_valid = 1'b0;
    logic [8:0] change_amt = '0;
    logic       change_ready;
    logic       refill = 1'b0;
    logic [5:0] refill_q = '0, refill_d = '0, refill_n = '0;
    logic       coin_ack = 1'b0;
    logic       eject_q, eject_d, eject_n;
    logic       busy, done, short_change, fault;
    logic [8:0] remaining;
    logic [4:0] quarter_cnt, dime_cnt, nickel_cnt;
    logic [5:0] stock_q, stock_d, stock_n;
    logic [2:0] fsm_state;

    change_dispenser_seq #(
        .PULSE_CYCLES(PULSE), .ACK_TIMEOUT(ACK_TO), .GAP_CYCLES(GAP), .STOCK_W(6)
    ) dut (
        .clk2(clk2), .rst(rst), .change_valid(change_valid), .change_amt(change_amt),
        .change_ready(change_ready), .refill(refill), .refill_q(refill_q),
        .refill_d(refill_d), .refill_n(refill_n), .coin_ack(coin_ack),
        .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n), .busy(busy),
        .done(done), .short_change(short_change), .fault(fault), .remaining(remaining),
        .quarter_cnt(quarter_cnt), .dime_cnt(dime_cnt), .nickel_cnt(nickel_cnt),
        .stock_q(stock_q), .stock_d(stock_d), .stock_n(stock_n), .fsm_state(fsm_state)
    );

    // 1 MHz clock
    always #500 clk2 = ~clk2;

    int tests_run = 0;
    int tests_failed = 0;

    // Coin codes used by the bench: 1 = quarter, 2 = dime, 3 = nickel.
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    // Reference model state
    int m_sq, m_sd, m_sn, m_rem, m_qc, m_dc, m_nc;
    bit m_short;

    // Observations from the last transaction
    bit o_done;
    int o_lat, o_rem, o_qc, o_dc, o_nc, o_sq, o_sd, o_sn;
    bit o_short;
    int bad_width, bad_onehot;

    typedef struct {
        int rq, rd, rn;
        int amt;
        int mode;            // 0 no refill, 1 refill before request, 2 refill with request
        int exp_n;
        logic [15:0] exp_seq;
        int qc, dc, nc;
        int rem;
        bit short_c;
        int sq, sd, sn;
        int lat;             // expected accept-to-done cycles, -1 when not checked
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Greedy payout computed from the rules: biggest coin that fits and is stocked.
    task automatic model_payout(input int amt);
        exp_q.delete();
        m_rem = amt; m_qc = 0; m_dc = 0; m_nc = 0;
        forever begin
            if (m_rem >= 25 && m_sq > 0) begin
                m_rem -= 25; m_sq--; m_qc = (m_qc < 31) ? m_qc + 1 : 31; exp_q.push_back(2'd1);
            end else if (m_rem >= 10 && m_sd > 0) begin
                m_rem -= 10; m_sd--; m_dc = (m_dc < 31) ? m_dc + 1 : 31; exp_q.push_back(2'd2);
            end else if (m_rem >= 5 && m_sn > 0) begin
                m_rem -= 5; m_sn--; m_nc = (m_nc < 31) ? m_nc + 1 : 31; exp_q.push_back(2'd3);
            end else begin
                break;
            end
        end
        m_short = (m_rem != 0);
    endtask

    // Issue one request and play the hopper until done (bounded).
    task automatic do_txn(input int amt, input int ack_dly, input bit early,
                          input int mode, input int rq, input int rd, input int rn);
        int cyc, hi_len, ack_cnt;
        bit pend;
        logic [2:0] ej, prev;
        obs_q.delete();
        o_done = 0; o_lat = -1; bad_width = 0; bad_onehot = 0;
        prev = '0; hi_len = 0; ack_cnt = 0; pend = 0;
        @(negedge clk2);
        if (mode == 1) begin
            refill = 1; refill_q = 6'(rq); refill_d = 6'(rd); refill_n = 6'(rn);
            @(negedge clk2);
            refill = 0;
        end
        change_valid = 1; change_amt = 9'(amt);
        if (mode == 2) begin
            refill = 1; refill_q = 6'(rq); refill_d = 6'(rd); refill_n = 6'(rn);
        end
        @(negedge clk2);
        change_valid = 0; refill = 0;
        cyc = 1;
        while (cyc < 3000) begin
            coin_ack = 0;
            ej = {eject_q, eject_d, eject_n};
            if ($countones(ej) > 1) bad_onehot++;
            if (ej != 3'b000) begin
                if (prev == 3'b000) begin
                    obs_q.push_back(ej[2] ? 2'd1 : (ej[1] ? 2'd2 : 2'd3));
                    hi_len = 0;
                    if (early) coin_ack = 1;
                end
                hi_len++;
            end else if (prev != 3'b000) begin
                if (hi_len != PULSE) bad_width++;
                if (!early) begin
                    pend = 1; ack_cnt = ack_dly;
                end
            end
            if (pend) begin
                if (ack_cnt == 0) begin
                    coin_ack = 1; pend = 0;
                end else begin
                    ack_cnt--;
                end
            end
            prev = ej;
            if (done) begin
                o_done = 1; o_lat = cyc; o_rem = remaining; o_short = short_change;
                o_qc = quarter_cnt; o_dc = dime_cnt; o_nc = nickel_cnt;
                o_sq = stock_q; o_sd = stock_d; o_sn = stock_n;
                break;
            end
            @(negedge clk2);
            cyc++;
        end
        coin_ack = 0;
    endtask

    task automatic check_txn(input string tag, input int rem, input bit sh,
                             input int qc, input int dc, input int nc,
                             input int sq, input int sd, input int sn);
        check({tag, "_done_seen"}, 32'(o_done), 1);
        check({tag, "_ncoins"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_coin"}, (i < obs_q.size()) ? 32'(obs_q[i]) : 32'd0, 32'(exp_q[i]));
        end
        check({tag, "_rem"}, o_rem, rem);
        check({tag, "_short"}, 32'(o_short), 32'(sh));
        check({tag, "_qcnt"}, o_qc, qc);
        check({tag, "_dcnt"}, o_dc, dc);
        check({tag, "_ncnt"}, o_nc, nc);
        check({tag, "_stock_q"}, o_sq, sq);
        check({tag, "_stock_d"}, o_sd, sd);
        check({tag, "_stock_n"}, o_sn, sn);
        check({tag, "_pulse_width_errs"}, bad_width, 0);
        check({tag, "_onehot_errs"}, bad_onehot, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ejects"}, {eject_q, eject_d, eject_n}, 0);
        check({tag, "_done_short_fault"}, {done, short_change, fault}, 0);
        check({tag, "_remaining"}, remaining, 0);
        check({tag, "_cnts"}, {quarter_cnt, dime_cnt, nickel_cnt}, 0);
        check({tag, "_stocks"}, {stock_q, stock_d, stock_n}, 0);
        check({tag, "_ready_busy"}, {change_ready, busy}, 2'b10);
    endtask

    initial begin
        int g, k, amt, mode, rq, rd, rn;
        vec_t v;

        vecs[0] = '{10, 10, 10, 65, 1, 4, 16'h00E5, 2, 1, 1, 0, 1'b0, 8, 9, 9, -1};
        vecs[1] = '{0, 10, 10, 40, 2, 4, 16'h00AA, 0, 4, 0, 0, 1'b0, 0, 6, 10, -1};
        vecs[2] = '{1, 0, 1, 35, 2, 2, 16'h000D, 1, 0, 1, 5, 1'b1, 0, 0, 0, -1};
        vecs[3] = '{10, 10, 10, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 1'b0, 10, 10, 10, 2};
        vecs[4] = '{0, 0, 0, 7, 0, 1, 16'h0003, 0, 0, 1, 2, 1'b1, 10, 10, 9, -1};

        // Reset
        rst = 1;
        repeat (3) @(negedge clk2);
        check_reset_values("reset");
        rst = 0;

        // Directed table
        for (int t = 0; t < 5; t++) begin
            v = vecs[t];
            exp_q.delete();
            for (int i = 0; i < v.exp_n; i++) exp_q.push_back(v.exp_seq[2*i +: 2]);
            do_txn(v.amt, t % 3, 1'b0, v.mode, v.rq, v.rd, v.rn);
            check_txn($sformatf("vec%0d", t), v.rem, v.short_c, v.qc, v.dc, v.nc,
                      v.sq, v.sd, v.sn);
            if (v.lat >= 0) check($sformatf("vec%0d_done_latency", t), o_lat, v.lat);
            repeat (2) @(negedge clk2);
            check($sformatf("vec%0d_hold_short", t), short_change, 32'(v.short_c));
            check($sformatf("vec%0d_hold_rem", t), remaining, v.rem);
            check($sformatf("vec%0d_idle_ready", t), {change_ready, busy, done}, 3'b100);
            m_sq = v.sq; m_sd = v.sd; m_sn = v.sn;
        end

        // Random payouts against the reference model
        for (int t = 0; t < 25; t++) begin
            mode = $urandom_range(0, 2);
            rq = m_sq; rd = m_sd; rn = m_sn;
            if (mode != 0) begin
                rq = $urandom_range(0, 15); rd = $urandom_range(0, 15); rn = $urandom_range(0, 15);
                m_sq = rq; m_sd = rd; m_sn = rn;
            end
            amt = $urandom_range(0, 160);
            model_payout(amt);
            do_txn(amt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), mode, rq, rd, rn);
            check_txn($sformatf("rnd%0d", t), m_rem, m_short, m_qc, m_dc, m_nc, m_sq, m_sd, m_sn);
        end

        // Withheld ack -> fault ACK_TO cycles after pulse end, then reset
        @(negedge clk2);
        refill = 1; refill_q = 6'd10; refill_d = 6'd10; refill_n = 6'd10;
        change_valid = 1; change_amt = 9'd25;
        @(negedge clk2);
        refill = 0; change_valid = 0;
        g = 0;
        while (!eject_q && g < 20) begin @(negedge clk2); g++; end
        check("fault_eject_seen", eject_q, 1);
        while (eject_q && g < 40) begin @(negedge clk2); g++; end
        k = 0;
        while (!fault && k < ACK_TO + 50) begin @(negedge clk2); k++; end
        check("fault_latency", k, ACK_TO);
        check("fault_outputs", {fault, eject_q, change_ready, busy, done}, 5'b10010);
        check("fault_rem_frozen", remaining, 25);
        coin_ack = 1;
        @(negedge clk2);
        coin_ack = 0;
        repeat (3) @(negedge clk2);
        check("fault_sticky", {fault, busy, change_ready}, 3'b110);
        check("fault_rem_after_late_ack", remaining, 25);
        rst = 1;
        @(negedge clk2);
        rst = 0;
        check_reset_values("fault_rst");

        // Reset during the second eject of a 50c payout; stray acks ignored
        @(negedge clk2);
        refill = 1; refill_q = 6'd10; refill_d = 6'd10; refill_n = 6'd10;
        change_valid = 1; change_amt = 9'd50;
        @(negedge clk2);
        refill = 0; change_valid = 0;
        g = 0;
        while (!eject_q && g < 20) begin @(negedge clk2); g++; end
        while (eject_q && g < 40) begin @(negedge clk2); g++; end
        coin_ack = 1;
        @(negedge clk2);
        coin_ack = 0;
        check("mid_after_ack_qcnt", quarter_cnt, 1);
        coin_ack = 1;                      // lands in GAP
        @(negedge clk2);
        coin_ack = 0;
        check("mid_gap_ack_qcnt", quarter_cnt, 1);
        check("mid_gap_ack_rem", remaining, 25);
        check("mid_gap_ack_stock", stock_q, 9);
        g = 0;
        while (!eject_q && g < 20) begin @(negedge clk2); g++; end
        check("mid_second_eject_seen", eject_q, 1);
        rst = 1;
        @(negedge clk2);
        rst = 0;
        check("mid_rst_eject_drop", eject_q, 0);
        check_reset_values("mid_rst");
        coin_ack = 1;                      // lands in IDLE
        @(negedge clk2);
        coin_ack = 0;
        @(negedge clk2);
        check("idle_ack_cnts", {quarter_cnt, dime_cnt, nickel_cnt}, 0);
        check("idle_ack_state", {busy, change_ready, remaining}, {2'b01, 9'd0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
